// File: rtl/mul_seq_ctrl.sv
// Sequencer for the shared 8x8 unsigned multiplier pair: steers operand bytes per step
// and accumulates the shifted 16-bit partial products into a 64-bit packed result.
module mul_seq_ctrl #(
  parameter int DATA_W   = 32,
  parameter int RESULT_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                kill,
  input  logic [1:0]          sew,
  input  logic [DATA_W-1:0]   data_in_A,
  input  logic [DATA_W-1:0]   data_in_B,
  output logic [7:0]          mult1_A,
  output logic [7:0]          mult1_B,
  output logic [7:0]          mult2_A,
  output logic [7:0]          mult2_B,
  input  logic [15:0]         mult1_P,
  input  logic [15:0]         mult2_P,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [RESULT_W-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [1:0]          sew_q;
  logic [2:0]          step_q;
  logic [RESULT_W-1:0] acc_q, result_q;
  logic                err_q;

  logic [1:0]          j1, k1, j2, k2;
  logic [5:0]          sh1, sh2;
  logic [2:0]          sum1, sum2;
  logic [3:0]          n1, n2;
  logic                lane;
  logic                last_step;
  logic [RESULT_W-1:0] prod1, prod2, acc_next;

  // Byte selection and shift for each multiplier, derived from sew and step.
  always_comb begin
    j1   = '0;
    k1   = '0;
    j2   = '0;
    k2   = '0;
    sh1  = '0;
    sh2  = '0;
    sum1 = '0;
    sum2 = '0;
    n1   = {step_q, 1'b0};
    n2   = {step_q, 1'b1};
    lane = step_q[1];
    case (sew_q)
      2'b00: begin
        j1  = {step_q[0], 1'b0};
        k1  = {step_q[0], 1'b0};
        j2  = {step_q[0], 1'b1};
        k2  = {step_q[0], 1'b1};
        sh1 = {step_q[0], 5'd0};
        sh2 = {step_q[0], 5'd16};
      end
      2'b01: begin
        j1 = {lane, 1'b0};
        j2 = {lane, 1'b1};
        if (!step_q[0]) begin
          k1  = {lane, 1'b0};
          k2  = {lane, 1'b1};
          sh1 = {lane, 5'd0};
          sh2 = {lane, 5'd16};
        end else begin
          k1  = {lane, 1'b1};
          k2  = {lane, 1'b0};
          sh1 = {lane, 5'd8};
          sh2 = {lane, 5'd8};
        end
      end
      default: begin
        j1   = n1[3:2];
        k1   = n1[1:0];
        j2   = n2[3:2];
        k2   = n2[1:0];
        sum1 = {1'b0, j1} + {1'b0, k1};
        sum2 = {1'b0, j2} + {1'b0, k2};
        sh1  = {sum1, 3'b000};
        sh2  = {sum2, 3'b000};
      end
    endcase
  end

  always_comb begin
    mult1_A = '0;
    mult1_B = '0;
    mult2_A = '0;
    mult2_B = '0;
    if (state_q == RUN) begin
      mult1_A = a_q[{j1, 3'b000} +: 8];
      mult1_B = b_q[{k1, 3'b000} +: 8];
      mult2_A = a_q[{j2, 3'b000} +: 8];
      mult2_B = b_q[{k2, 3'b000} +: 8];
    end
  end

  always_comb begin
    prod1    = {{(RESULT_W-16){1'b0}}, mult1_P} << sh1;
    prod2    = {{(RESULT_W-16){1'b0}}, mult2_P} << sh2;
    acc_next = acc_q + prod1 + prod2;
    case (sew_q)
      2'b00:   last_step = (step_q == 3'd1);
      2'b01:   last_step = (step_q == 3'd3);
      default: last_step = (step_q == 3'd7);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (sew == 2'b11) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        // kill takes precedence over completing on the last step
        if (kill)           state_d = IDLE;
        else if (last_step) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      sew_q    <= '0;
      step_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q    <= data_in_A;
            b_q    <= data_in_B;
            sew_q  <= sew;
            step_q <= '0;
            acc_q  <= '0;
            err_q  <= (sew == 2'b11);
            if (sew == 2'b11) result_q <= '0;
          end
        end
        RUN: begin
          if (!kill) begin
            acc_q  <= acc_next;
            step_q <= step_q + 3'd1;
            if (last_step) result_q <= acc_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed and randomized bench for mul_seq_ctrl with a lane-arithmetic reference model.
module tb_mul_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        kill;
  logic [1:0]  sew;
  logic [31:0] data_in_A, data_in_B;
  logic [7:0]  mult1_A, mult1_B, mult2_A, mult2_B;
  logic [15:0] mult1_P, mult2_P;
  logic        busy, done, err;
  logic [63:0] result;

  int unsigned passes;
  int unsigned total;
  int unsigned fails;

  mul_seq_ctrl #(.DATA_W(32), .RESULT_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .kill      (kill),
    .sew       (sew),
    .data_in_A (data_in_A),
    .data_in_B (data_in_B),
    .mult1_A   (mult1_A),
    .mult1_B   (mult1_B),
    .mult2_A   (mult2_A),
    .mult2_B   (mult2_B),
    .mult1_P   (mult1_P),
    .mult2_P   (mult2_P),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result)
  );

  assign mult1_P = {8'b0, mult1_A} * {8'b0, mult1_B};
  assign mult2_P = {8'b0, mult2_A} * {8'b0, mult2_B};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] s);
    logic [63:0] r;
    logic [15:0] p16;
    logic [31:0] p32;
    r = '0;
    case (s)
      2'b00:
        for (int i = 0; i < 4; i++) begin
          p16 = {8'b0, a[8*i +: 8]} * {8'b0, b[8*i +: 8]};
          r[16*i +: 16] = p16;
        end
      2'b01:
        for (int l = 0; l < 2; l++) begin
          p32 = {16'b0, a[16*l +: 16]} * {16'b0, b[16*l +: 16]};
          r[32*l +: 32] = p32;
        end
      2'b10: r = {32'b0, a} * {32'b0, b};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [1:0] s);
    case (s)
      2'b00:   return 3;
      2'b01:   return 5;
      2'b10:   return 9;
      default: return 1;
    endcase
  endfunction

  task automatic check_ops_zero(input string tag);
    check({tag, "_mops"}, {32'b0, mult1_A, mult1_B, mult2_A, mult2_B}, 64'd0);
  endtask

  // Called at posedge+1 in an IDLE cycle; returns at posedge+1 of the IDLE cycle after done.
  // With hold set, start stays high and operands are replaced after acceptance.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] s, input logic [63:0] exp, input bit hold,
                       input bit kill0);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    data_in_A = a;
    data_in_B = b;
    sew   = s;
    start = 1'b1;
    kill  = kill0;
    while (!got && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      kill = 1'b0;
      if (hold) begin
        data_in_A = $urandom;
        data_in_B = $urandom;
        sew = 2'(($urandom % 3));
      end else begin
        start = 1'b0;
      end
      if (done) got = 1'b1;
      else if (s == 2'b11) check_ops_zero({tag, "_run"});
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'(ref_latency(s)));
    check({tag, "_result"}, result, exp);
    check({tag, "_err"}, 64'(err), 64'(s == 2'b11));
    check({tag, "_busy_done"}, 64'(busy), 64'd1);
    check_ops_zero({tag, "_done"});
    @(posedge clk);
    #1;
    check({tag, "_pulse_end"}, {62'b0, done, busy}, 64'd0);
    check({tag, "_held"}, result, exp);
    check_ops_zero({tag, "_idle"});
  endtask

  logic [31:0] ra, rb, a2, b2;
  logic [1:0]  rs;
  logic [63:0] prev;

  initial begin
    passes = 0;
    total  = 0;
    fails  = 0;
    reset = 1'b1;
    start = 1'b0;
    kill  = 1'b0;
    sew   = 2'b00;
    data_in_A = '0;
    data_in_B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {busy, done, err, 61'b0}, 64'd0);
    check("reset_result", result, 64'd0);
    check_ops_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_op("t1_sew00", 32'h11223344, 32'h55667788, 2'b00, 64'h05A5_0D8C_17B5_2420, 1'b0, 1'b0);
    do_op("t2_sew01", 32'h11223344, 32'h55667788, 2'b01, 64'h05B71D8C_17EFD820, 1'b0, 1'b0);
    do_op("t3_sew10", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 64'hFFFFFFFE_00000001, 1'b0, 1'b0);
    do_op("t3_sew00", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 64'hFE01_FE01_FE01_FE01, 1'b0, 1'b0);

    // start held high: one op, operands changed mid-op are ignored, restart from IDLE
    ra = 32'hDEADBEEF;
    rb = 32'h12345678;
    do_op("t4_hold", ra, rb, 2'b10, ref_result(ra, rb, 2'b10), 1'b1, 1'b0);
    a2 = data_in_A;
    b2 = data_in_B;
    rs = sew;
    do_op("t4_restart", a2, b2, rs, ref_result(a2, b2, rs), 1'b0, 1'b0);

    // kill asserted alongside an accepted start in IDLE has no effect
    ra = $urandom;
    rb = $urandom;
    do_op("t5_kill_idle", ra, rb, 2'b01, ref_result(ra, rb, 2'b01), 1'b0, 1'b1);

    // kill at RUN step 3 of a sew10 op
    prev = result;
    data_in_A = $urandom;
    data_in_B = $urandom;
    sew   = 2'b10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("t5_step3_busy", 64'(busy), 64'd1);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("t5_kill_idle_next", {62'b0, busy, done}, 64'd0);
    check("t5_kill_result", result, prev);
    check_ops_zero("t5_kill");
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("t5_no_done", {62'b0, busy, done}, 64'd0);
    end

    // reset in the middle of a fresh op
    data_in_A = 32'hA5A5A5A5;
    data_in_B = 32'h5A5A5A5A;
    sew   = 2'b10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t5_rst_outs", {busy, done, err, 61'b0}, 64'd0);
    check("t5_rst_result", result, 64'd0);
    check_ops_zero("t5_rst");

    ra = $urandom;
    rb = $urandom;
    do_op("t6_illegal", ra, rb, 2'b11, 64'd0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 2'($urandom_range(0, 3));
      do_op("rand", ra, rb, rs, ref_result(ra, rb, rs), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
